// File: rtl/packet_length_prepender.sv
// packet_length_prepender
//
// Framing stage that sits after the packet analyzer. Each entry on the size
// stream is paired with one packet from the body stream. The block emits a
// single AXI-Stream that carries a header beat ahead of every packet. The
// header holds the reported byte length in [15:0] and a 16-bit sequence
// number in [31:16]. The block also recounts the body bytes from tkeep and
// flags any packet whose byte count differs from the reported size.
//
// Ports:
//   clk, resetn              clock; synchronous active-low reset
//   axis_size_*              reported packet byte length (tdata 16 bits)
//   axis_body_*              packet body beats (tdata DW, tkeep DW/8, tlast)
//   axis_out_*               framed output: header beat, then the body beats
//   len_err                  one-cycle pulse that coincides with the tlast beat
//                            of a packet whose length does not match
//   err_count                number of mismatches, saturates at 0xFFFF
//   pkt_count                number of completed packets, wraps
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high. A valid beat on axis_out holds its data until it is accepted.
// Both input readies depend only on state, reset and axis_out_tready. They
// never depend on the input tvalids.
//
// FSM state is held in the 'state' signal (IDLE / BODY) for checker binding.

module packet_length_prepender #(
    parameter int DW = 128
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [15:0]       axis_size_tdata,
    input  logic              axis_size_tvalid,
    output logic              axis_size_tready,
    input  logic [DW-1:0]     axis_body_tdata,
    input  logic [DW/8-1:0]   axis_body_tkeep,
    input  logic              axis_body_tlast,
    input  logic              axis_body_tvalid,
    output logic              axis_body_tready,
    output logic [DW-1:0]     axis_out_tdata,
    output logic [DW/8-1:0]   axis_out_tkeep,
    output logic              axis_out_tlast,
    output logic              axis_out_tvalid,
    input  logic              axis_out_tready,
    output logic              len_err,
    output logic [15:0]       err_count,
    output logic [31:0]       pkt_count
);

    localparam int KW = DW / 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] seq;
    logic [15:0] acc;
    logic [15:0] expected;

    logic          slot;
    logic [15:0]   beat_bytes;
    logic [15:0]   total;
    logic [DW-1:0] hdr;

    // The output register can take a new beat when it is empty or being drained.
    assign slot = !axis_out_tvalid || axis_out_tready;

    // Gating with resetn keeps both readies low during the reset cycle itself.
    assign axis_size_tready = resetn && (state == IDLE) && slot;
    assign axis_body_tready = resetn && (state == BODY) && slot;

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < KW; i++) begin
            beat_bytes = beat_bytes + 16'(axis_body_tkeep[i]);
        end
        // Byte count of the packet including the beat now being accepted.
        total = acc + beat_bytes;
        hdr = '0;
        hdr[15:0]  = axis_size_tdata;
        hdr[31:16] = seq;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= IDLE;
            seq             <= '0;
            acc             <= '0;
            expected        <= '0;
            axis_out_tvalid <= 1'b0;
            axis_out_tdata  <= '0;
            axis_out_tkeep  <= '0;
            axis_out_tlast  <= 1'b0;
            len_err         <= 1'b0;
            err_count       <= '0;
            pkt_count       <= '0;
        end else begin
            len_err <= 1'b0;
            // The register empties when it is drained and no new beat loads.
            if (slot) begin
                axis_out_tvalid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (axis_size_tvalid && axis_size_tready) begin
                        axis_out_tvalid <= 1'b1;
                        axis_out_tdata  <= hdr;
                        axis_out_tkeep  <= '1;
                        axis_out_tlast  <= 1'b0;
                        expected        <= axis_size_tdata;
                        acc             <= '0;
                        seq             <= seq + 16'd1;
                        state           <= BODY;
                    end
                end
                BODY: begin
                    if (axis_body_tvalid && axis_body_tready) begin
                        axis_out_tvalid <= 1'b1;
                        axis_out_tdata  <= axis_body_tdata;
                        axis_out_tkeep  <= axis_body_tkeep;
                        axis_out_tlast  <= axis_body_tlast;
                        acc             <= total;
                        if (axis_body_tlast) begin
                            if (total != expected) begin
                                len_err <= 1'b1;
                                if (err_count != 16'hFFFF) begin
                                    err_count <= err_count + 16'd1;
                                end
                            end
                            pkt_count <= pkt_count + 32'd1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_length_prepender.sv
// Testbench for packet_length_prepender: directed packets plus a randomised
// backpressure run. A scoreboard holds every expected output beat, and a
// model holds the expected sequence number and counters.

module tb_packet_length_prepender;

    localparam int DW = 128;
    localparam int KW = DW / 8;
    localparam int EW = DW + KW + 2;   // {len_err, tlast, tkeep, tdata}

    logic            clk;
    logic            resetn;
    logic [15:0]     axis_size_tdata;
    logic            axis_size_tvalid;
    logic            axis_size_tready;
    logic [DW-1:0]   axis_body_tdata;
    logic [KW-1:0]   axis_body_tkeep;
    logic            axis_body_tlast;
    logic            axis_body_tvalid;
    logic            axis_body_tready;
    logic [DW-1:0]   axis_out_tdata;
    logic [KW-1:0]   axis_out_tkeep;
    logic            axis_out_tlast;
    logic            axis_out_tvalid;
    logic            axis_out_tready;
    logic            len_err;
    logic [15:0]     err_count;
    logic [31:0]     pkt_count;

    packet_length_prepender #(.DW(DW)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .axis_size_tdata  (axis_size_tdata),
        .axis_size_tvalid (axis_size_tvalid),
        .axis_size_tready (axis_size_tready),
        .axis_body_tdata  (axis_body_tdata),
        .axis_body_tkeep  (axis_body_tkeep),
        .axis_body_tlast  (axis_body_tlast),
        .axis_body_tvalid (axis_body_tvalid),
        .axis_body_tready (axis_body_tready),
        .axis_out_tdata   (axis_out_tdata),
        .axis_out_tkeep   (axis_out_tkeep),
        .axis_out_tlast   (axis_out_tlast),
        .axis_out_tvalid  (axis_out_tvalid),
        .axis_out_tready  (axis_out_tready),
        .len_err          (len_err),
        .err_count        (err_count),
        .pkt_count        (pkt_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared state ----------------
    logic [EW-1:0]   exp_q[$];
    logic [15:0]     size_q[$];
    logic [DW+KW:0]  body_q[$];        // {tlast, tkeep, tdata}

    int checks = 0;
    int errors = 0;
    int in_gap = 0;                    // percent of cycles an input withholds valid
    int rdy_pct = 100;                 // percent of cycles axis_out_tready is high
    int popped = 0;

    logic [15:0] model_seq;
    logic [15:0] model_err;
    logic [31:0] model_pkt;
    logic [15:0] pk[8];
    bit          s_acc;
    bit          b_acc;
    bit          stalled_prev;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    initial begin
        axis_out_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            axis_out_tready = ($urandom_range(99) < rdy_pct);
        end
    end

    initial begin
        axis_size_tvalid = 1'b0;
        axis_size_tdata  = '0;
        forever begin
            @(negedge clk);
            s_acc = axis_size_tvalid && axis_size_tready;
            @(posedge clk);
            #1;
            if (s_acc) begin
                void'(size_q.pop_front());
                axis_size_tvalid = 1'b0;
            end
            if (!resetn) begin
                axis_size_tvalid = 1'b0;
            end else if (!axis_size_tvalid && size_q.size() > 0 && $urandom_range(99) >= in_gap) begin
                axis_size_tvalid = 1'b1;
                axis_size_tdata  = size_q[0];
            end
        end
    end

    initial begin
        axis_body_tvalid = 1'b0;
        axis_body_tdata  = '0;
        axis_body_tkeep  = '0;
        axis_body_tlast  = 1'b0;
        forever begin
            @(negedge clk);
            b_acc = axis_body_tvalid && axis_body_tready;
            @(posedge clk);
            #1;
            if (b_acc) begin
                void'(body_q.pop_front());
                axis_body_tvalid = 1'b0;
            end
            if (!resetn) begin
                axis_body_tvalid = 1'b0;
            end else if (!axis_body_tvalid && body_q.size() > 0 && $urandom_range(99) >= in_gap) begin
                axis_body_tvalid = 1'b1;
                {axis_body_tlast, axis_body_tkeep, axis_body_tdata} = body_q[0];
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    // len_err belongs to the first cycle a beat is presented. If that beat is
    // stalled, the pulse is over in the cycles that follow.
    always @(negedge clk) begin
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        if (!resetn) begin
            stalled_prev = 1'b0;
        end else if (axis_out_tvalid) begin
            got = {len_err, axis_out_tlast, axis_out_tkeep, axis_out_tdata};
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 256'(got), 256'(0));
            end else begin
                exp = exp_q[0];
                if (stalled_prev) exp[EW-1] = 1'b0;
                if (axis_out_tready) begin
                    check("out_beat", 256'(got), 256'(exp));
                    void'(exp_q.pop_front());
                    popped++;
                end else begin
                    check("stall_hold", 256'(got), 256'(exp));
                    check("stall_readies", 256'({axis_size_tready, axis_body_tready}), 256'(0));
                end
            end
            stalled_prev = !axis_out_tready;
        end else begin
            check("idle_len_err", 256'(len_err), 256'(0));
            stalled_prev = 1'b0;
        end
    end

    // ---------------- stimulus tasks ----------------
    // Queues one packet of n beats that use the tkeep values in pk[]. With
    // use_forced set, the reported size is 'forced'; otherwise it is the
    // true byte count.
    task automatic add_pkt(input int n, input bit use_forced, input logic [15:0] forced);
        logic [15:0]   total;
        logic [15:0]   size;
        logic [DW-1:0] d;
        logic [DW-1:0] hdr;
        bit            last;
        total = '0;
        for (int i = 0; i < n; i++) total = total + 16'($countones(pk[i]));
        size = use_forced ? forced : total;
        hdr = '0;
        hdr[15:0]  = size;
        hdr[31:16] = model_seq;
        exp_q.push_back({1'b0, 1'b0, {KW{1'b1}}, hdr});
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom;
            last = (i == n - 1);
            body_q.push_back({last, pk[i], d});
            exp_q.push_back({last && (size != total), last, pk[i], d});
        end
        size_q.push_back(size);
        model_seq = model_seq + 16'd1;
        model_pkt = model_pkt + 32'd1;
        if (size != total && model_err != 16'hFFFF) model_err = model_err + 16'd1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || size_q.size() > 0 || body_q.size() > 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain_timeout"}, 256'(n >= 5000), 256'(0));
        repeat (3) @(negedge clk);
        check({tag, "_pkt_count"}, 256'(pkt_count), 256'(model_pkt));
        check({tag, "_err_count"}, 256'(err_count), 256'(model_err));
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        size_q.delete();
        body_q.delete();
        exp_q.delete();
        model_seq = '0;
        model_pkt = '0;
        model_err = '0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 256'(axis_out_tvalid), 256'(0));
        check("rst_out", 256'({axis_out_tdata, axis_out_tkeep, axis_out_tlast}), 256'(0));
        check("rst_len_err", 256'(len_err), 256'(0));
        check("rst_counters", 256'({err_count, pkt_count}), 256'(0));
        check("rst_readies", 256'({axis_size_tready, axis_body_tready}), 256'(0));
        @(posedge clk);
        #2;
        resetn = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int start;
        int nb;
        logic [15:0] tot;
        resetn = 1'b0;
        model_seq = '0;
        model_pkt = '0;
        model_err = '0;
        do_reset(3);

        // single packet: 16 + 16 + 8 = 40 bytes
        pk[0] = 16'hFFFF; pk[1] = 16'hFFFF; pk[2] = 16'h00FF;
        add_pkt(3, 1'b1, 16'd40);
        drain("single");
        check("single_pkt_is_1", 256'(pkt_count), 256'(1));

        // back-to-back: H, B, H, B with no gaps
        pk[0] = 16'hFFFF; add_pkt(1, 1'b1, 16'd16);
        pk[0] = 16'h001F; add_pkt(1, 1'b1, 16'd5);
        n = 0;
        @(negedge clk);
        while (!axis_out_tvalid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_start_timeout", 256'(n >= 100), 256'(0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("b2b_no_gap", 256'(axis_out_tvalid), 256'(1));
        end
        drain("b2b");

        // mismatch: size 32, body carries 8 bytes
        pk[0] = 16'h00FF;
        add_pkt(1, 1'b1, 16'd32);
        drain("mismatch");
        check("mismatch_err_is_1", 256'(err_count), 256'(1));

        // random backpressure over 100 packets
        in_gap = 30;
        rdy_pct = 50;
        for (int p = 0; p < 100; p++) begin
            nb = $urandom_range(1, 4);
            tot = '0;
            for (int i = 0; i < nb; i++) begin
                case ($urandom_range(4))
                    0: pk[i] = 16'hFFFF;
                    1: pk[i] = 16'h00FF;
                    2: pk[i] = 16'h0001;
                    3: pk[i] = 16'h0000;
                    default: pk[i] = 16'($urandom);
                endcase
                tot = tot + 16'($countones(pk[i]));
            end
            if ($urandom_range(4) == 0) add_pkt(nb, 1'b1, tot + 16'($urandom_range(1, 3)));
            else add_pkt(nb, 1'b0, 16'd0);
        end
        drain("random");

        // all-zero tkeep: matches only a size of 0
        in_gap = 0;
        rdy_pct = 100;
        pk[0] = 16'h0000; pk[1] = 16'h0000;
        add_pkt(2, 1'b1, 16'd0);
        add_pkt(2, 1'b1, 16'd1);
        drain("zero_keep");

        // sequence wrap and error saturation, preloaded near their limits
        force dut.seq = 16'hFFFF;
        force dut.err_count = 16'hFFFE;
        @(negedge clk);
        release dut.seq;
        release dut.err_count;
        model_seq = 16'hFFFF;
        model_err = 16'hFFFE;
        pk[0] = 16'h00FF;
        for (int p = 0; p < 3; p++) add_pkt(1, 1'b1, 16'd1);
        drain("wrap_sat");
        check("sat_err_ffff", 256'(err_count), 256'(16'hFFFF));

        // reset after the header and one body beat have gone out
        pk[0] = 16'hFFFF; pk[1] = 16'hFFFF; pk[2] = 16'hFFFF;
        start = popped;
        add_pkt(3, 1'b1, 16'd48);
        n = 0;
        while (popped < start + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("midpkt_timeout", 256'(n >= 500), 256'(0));
        do_reset(1);
        pk[0] = 16'hFFFF;
        add_pkt(1, 1'b1, 16'd16);       // header must carry seq 0
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
